// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_resp
//  Description : Data-side SRAM with a fixed number of wait states in front of
//                each response. A request is captured in IDLE, optionally
//                delayed in WAIT, and answered in a single RESP cycle. Reads
//                return the whole aligned word. Writes update only the strobed
//                byte lanes. Addresses outside the array flag addr_err.
//  Ports       : clk        - clock, rising edge active
//                rst        - synchronous active-high reset
//                mem_en     - request valid
//                mem_wen    - byte-lane write strobes (0000 = read)
//                mem_addr   - byte address
//                mem_wdata  - lane-aligned store data
//                mem_rdata  - read data, held until the next read response
//                mem_stall  - pipeline freeze request (combinational)
//                mem_rvalid - one-cycle completion pulse
//                addr_err   - one-cycle out-of-range pulse with mem_rvalid
//  Revision    : 1.0 - initial release
// ============================================================================
module data_sram_resp #(
    parameter int          AW   = 10,
    parameter int          WAIT = 2,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_rvalid,
    output logic        addr_err
);

    localparam logic [1:0] C_S_IDLE   = 2'd0;
    localparam logic [1:0] C_S_WAIT   = 2'd1;
    localparam logic [1:0] C_S_RESP   = 2'd2;
    localparam logic [3:0] C_CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
    localparam int         C_DEPTH    = 1 << AW;

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wen;
    logic [31:0]   r_mem [C_DEPTH];

    logic [31:0]   w_addr;
    logic [3:0]    w_wen;
    logic [31:0]   w_off;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_capture;
    logic          w_enter_resp;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            C_S_IDLE: if (mem_en) w_next = (WAIT > 0) ? C_S_WAIT : C_S_RESP;
            C_S_WAIT: if (r_cnt == 4'd0) w_next = C_S_RESP;
            C_S_RESP: w_next = C_S_IDLE;
            default:  w_next = C_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_stall = ((r_state == C_S_IDLE) && mem_en) || (r_state == C_S_WAIT);
    end

    assign w_capture    = (r_state == C_S_IDLE) && mem_en;
    assign w_enter_resp = (w_next == C_S_RESP) && (r_state != C_S_RESP);

    // With zero wait states the array is read on the capture edge itself, so
    // the live request is decoded while in IDLE; afterwards only the captured
    // copy is used.
    assign w_addr     = (r_state == C_S_IDLE) ? mem_addr : r_addr;
    assign w_wen      = (r_state == C_S_IDLE) ? mem_wen  : r_wen;
    assign w_off      = w_addr - BASE;
    assign w_in_range = (w_addr >= BASE) && ((w_off >> (AW + 2)) == 32'd0);
    assign w_idx      = w_off[AW+1:2];

    // ------------------------------------------------------------------
    // Request capture and wait-state counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wen   <= 4'd0;
        end else if (w_capture) begin
            r_cnt   <= C_CNT_INIT;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wen   <= mem_wen;
        end else if ((r_state == C_S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Response registers, loaded on the edge that enters RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rdata  <= 32'd0;
            mem_rvalid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            mem_rvalid <= w_enter_resp;
            addr_err   <= w_enter_resp && !w_in_range;
            if (w_enter_resp && (w_wen == 4'd0)) begin
                mem_rdata <= w_in_range ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Array write: commits at the end of RESP; a reset in that cycle aborts
    // it. The array itself is never cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && (r_state == C_S_RESP) && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wen[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
